// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for fifo_rr_ctrl and its round-robin arbiter.
package fifo_ctrl_pkg;

  localparam int OUT_BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;
  // Wider view for buffer occupancy plus the in-flight read, so the sum never wraps.
  typedef logic [2:0] occ_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after rr_ptr_i,
// wrapping modulo NUM_REQ (no power-of-two assumption).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_valid_o
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output gets a default before the search so no path infers a latch;
    // combinational logic uses blocking assignments so later lines see earlier results.
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[IDX_W'(idx)]) begin
        found    = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
    grant_o[winner_o] = found;
  end

  assign any_valid_o = |req_valid_i;

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Round-robin write-port sharing in front of a sync_fifo and a 2-entry output buffer
// behind it. Define FIFO_RR_CTRL_STATS_EN to add enq_count / full_stall_count outputs.
module fifo_rr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_enqueue,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_is_full,
  output logic                          fifo_dequeue,
  input  logic [DATA_WIDTH-1:0]         fifo_rdata,
  input  logic                          fifo_is_empty,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
`ifdef FIFO_RR_CTRL_STATS_EN
  output logic [31:0]                   enq_count,
  output logic [31:0]                   full_stall_count,
`endif
  input  logic                          out_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // ---------------- enqueue side ----------------
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               any_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  assign fifo_enqueue = any_valid && !fifo_is_full;
  assign req_ready    = fifo_enqueue ? grant : '0;
  assign fifo_wdata   = any_valid ? req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fifo_enqueue) rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  end

  // ---------------- dequeue side ----------------
  logic [DATA_WIDTH-1:0] buf_q [OUT_BUF_DEPTH];
  logic                  head_q;
  logic                  tail;
  buf_cnt_t              buf_count_q, buf_count_d;
  logic                  rd_pending_q;
  logic                  pop;
  occ_t                  occ_after_pop;

  assign out_valid = (buf_count_q != '0);
  assign out_data  = buf_q[head_q];
  assign pop       = out_valid && out_ready;

  // Words held or in flight after this cycle's pop; a new read is issued only if it
  // will still find a free slot when it arrives.
  assign occ_after_pop = occ_t'(buf_count_q) + occ_t'(rd_pending_q) - occ_t'(pop);
  assign fifo_dequeue  = !fifo_is_empty && (occ_after_pop < occ_t'(OUT_BUF_DEPTH));
  assign buf_count_d   = buf_cnt_t'(occ_after_pop);
  assign tail          = head_q ^ buf_count_q[0];

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      head_q       <= 1'b0;
      buf_count_q  <= '0;
      rd_pending_q <= 1'b0;
      // NOTE: the two buffer slots are cleared too, because out_data reads 0 after reset.
      for (int i = 0; i < OUT_BUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      buf_count_q  <= buf_count_d;
      rd_pending_q <= fifo_dequeue;
      if (pop) head_q <= ~head_q;
      if (rd_pending_q) buf_q[tail] <= fifo_rdata;
    end
  end

`ifdef FIFO_RR_CTRL_STATS_EN
  logic [31:0] enq_count_q, full_stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      enq_count_q        <= '0;
      full_stall_count_q <= '0;
    end else begin
      if (fifo_enqueue) enq_count_q <= sat_inc(enq_count_q);
      if (any_valid && fifo_is_full) full_stall_count_q <= sat_inc(full_stall_count_q);
    end
  end

  assign enq_count        = enq_count_q;
  assign full_stall_count = full_stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Self-checking bench for fifo_rr_ctrl with a behavioural 16-deep sync_fifo and a
// transaction-level reference model (arbitration by distance, scoreboard, word counts).
module tb_fifo_rr_ctrl;

  localparam int NUM_REQ = 4;
  localparam int DW      = 64;
  localparam int DEPTH   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   fifo_enqueue;
  logic [DW-1:0]          fifo_wdata;
  logic                   fifo_is_full  = 1'b0;
  logic                   fifo_dequeue;
  logic [DW-1:0]          fifo_rdata    = '0;
  logic                   fifo_is_empty = 1'b1;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic                   out_ready;
`ifdef FIFO_RR_CTRL_STATS_EN
  logic [31:0]            enq_count;
  logic [31:0]            full_stall_count;
`endif

  always #5 clk = ~clk;

  fifo_rr_ctrl #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_enqueue     (fifo_enqueue),
    .fifo_wdata       (fifo_wdata),
    .fifo_is_full     (fifo_is_full),
    .fifo_dequeue     (fifo_dequeue),
    .fifo_rdata       (fifo_rdata),
    .fifo_is_empty    (fifo_is_empty),
    .out_valid        (out_valid),
    .out_data         (out_data),
`ifdef FIFO_RR_CTRL_STATS_EN
    .enq_count        (enq_count),
    .full_stall_count (full_stall_count),
`endif
    .out_ready        (out_ready)
  );

  // Behavioural sync_fifo: registered read data, flags registered from occupancy.
  logic [DW-1:0] fq[$];
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_rdata <= '0;
    end else begin
      if (fifo_dequeue && fq.size() != 0) fifo_rdata <= fq.pop_front();
      if (fifo_enqueue && fq.size() < DEPTH) fq.push_back(fifo_wdata);
    end
    fifo_is_full  <= (fq.size() == DEPTH);
    fifo_is_empty <= (fq.size() == 0);
  end

  // ---------------- reference model state ----------------
  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 cyc      = 0;
  int                 seq      = 0;
  int                 exp_ptr;
  int                 held;          // words dequeued from the FIFO and not yet popped
  bit                 last_deq;      // a dequeue in the previous cycle is still in flight
  logic [DW-1:0]      sb[$];         // accepted words, in expected output order
  logic [NUM_REQ-1:0] acc_mask;
  logic [NUM_REQ-1:0] ready_seen;
  int                 last_winner;
  int                 grants[NUM_REQ];
  int                 n_pops, first_enq_cyc, first_pop_cyc, last_pop_cyc, stall_cycles;
  longint             exp_enq_cnt, exp_stall_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Winner = valid producer at the smallest forward distance from the pointer.
  function automatic int exp_winner();
    int best, best_d, d;
    best = -1;
    best_d = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i - exp_ptr + NUM_REQ) % NUM_REQ;
      if (req_valid[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    return best;
  endfunction

  task automatic clear_model();
    exp_ptr = 0; held = 0; last_deq = 0; sb.delete();
    acc_mask = '0; ready_seen = '0; last_winner = -1;
    for (int i = 0; i < NUM_REQ; i++) grants[i] = 0;
    n_pops = 0; first_enq_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    stall_cycles = 0; exp_enq_cnt = 0; exp_stall_cnt = 0;
  endtask

  // Compare one cycle at the negative edge and advance the model across the next edge.
  task automatic evaluate();
    int                 w;
    logic               any, full, pop, exp_ov, exp_deq;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [DW-1:0]      exp_wd;
    any     = |req_valid;
    full    = (fq.size() == DEPTH);
    w       = exp_winner();
    exp_rdy = '0;
    exp_wd  = '0;
    if (any) exp_wd = req_data[w*DW +: DW];
    if (any && !full) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("fifo_enqueue", fifo_enqueue, any && !full);
    check("fifo_wdata", fifo_wdata, exp_wd);
    exp_ov = (held - int'(last_deq)) > 0;
    check("out_valid", out_valid, exp_ov);
    pop = exp_ov && out_ready;
    if (pop) begin
      if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
      else check("scoreboard_nonempty", sb.size(), 1);
      n_pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    exp_deq = (fq.size() != 0) && ((held - int'(pop)) < 2);
    check("fifo_dequeue", fifo_dequeue, exp_deq);
    check("buf_count_le2", dut.buf_count_q <= 2'd2, 1'b1);
`ifdef FIFO_RR_CTRL_STATS_EN
    check("enq_count", enq_count, exp_enq_cnt);
    check("full_stall_count", full_stall_count, exp_stall_cnt);
`endif
    ready_seen = ready_seen | req_ready;
    acc_mask   = exp_rdy;
    if (any && !full) begin
      sb.push_back(exp_wd);
      exp_ptr     = (w + 1) % NUM_REQ;
      last_winner = w;
      grants[w]++;
      exp_enq_cnt++;
      if (first_enq_cyc < 0) first_enq_cyc = cyc;
    end else begin
      last_winner = -1;
    end
    if (any && full) begin
      exp_stall_cnt++;
      stall_cycles++;
    end
    held     = held + int'(exp_deq) - int'(pop);
    last_deq = exp_deq;
  endtask

  task automatic step();
    @(negedge clk);
    evaluate();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Retire accepted requests, then raise new ones on idle lanes in mask with pct% chance.
  task automatic drive(input logic [NUM_REQ-1:0] mask, input int pct);
    req_valid = req_valid & ~acc_mask;
    acc_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && !req_valid[i] && (int'($urandom_range(99)) < pct)) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = {8'(i), 24'(seq), 32'($urandom())};
        seq++;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_fifo_enqueue", fifo_enqueue, 1'b0);
    check("rst_fifo_dequeue", fifo_dequeue, 1'b0);
`ifdef FIFO_RR_CTRL_STATS_EN
    check("rst_enq_count", enq_count, '0);
    check("rst_full_stall_count", full_stall_count, '0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ptr_checked;
    int stream_k;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    do_reset();

    // Fairness: all producers valid, grants rotate 0,1,2,3 one per cycle.
    out_ready = 1'b1;
    drive('1, 100);
    for (int k = 0; k < 16; k++) begin
      step();
      check("fair_order", last_winner, k % NUM_REQ);
      drive('1, 100);
    end
    for (int i = 0; i < NUM_REQ; i++) check("fair_share", grants[i], 4);

    // Skip idle producers: move pointer to 2 via producer 1, then 1 and 3 compete.
    do_reset();
    drive(4'b0010, 100);
    step();
    check("skip_first", last_winner, 1);
    drive(4'b1010, 100);
    for (int k = 0; k < 3; k++) begin
      step();
      check("skip_order", last_winner, (k % 2 == 0) ? 3 : 1);
      drive(4'b1010, 100);
    end
    check("skip_idle_never_ready", ready_seen & 4'b0101, '0);

    // FIFO full: no consumer, 16 in FIFO + 2 in controller, then stalls.
    do_reset();
    out_ready = 1'b0;
    drive('1, 100);
    for (int k = 0; k < 30; k++) begin
      step();
      drive('1, 100);
    end
    check("full_accepted", sb.size(), 18);
    check("full_stall_cycles", stall_cycles, 12);
    check("full_no_ready", req_ready, '0);
    out_ready   = 1'b1;
    ptr_checked = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!ptr_checked && last_winner >= 0) begin
        check("full_ptr_frozen", last_winner, 2);
        ptr_checked = 1'b1;
      end
      drive('0, 0);
    end
    check("full_drained", sb.size(), 0);
    check("full_all_accepted", req_valid, '0);

    // Streaming order and latency: 0x10..0x1F from producer 0 with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    stream_k  = 0;
    req_valid[0]     = 1'b1;
    req_data[0+:DW]  = DW'(32'h10);
    for (int k = 0; k < 30; k++) begin
      step();
      if (acc_mask[0]) begin
        acc_mask[0] = 1'b0;
        stream_k++;
        req_valid[0] = (stream_k < 16);
        req_data[0+:DW] = DW'(32'h10 + stream_k);
      end
    end
    check("stream_beats", n_pops, 16);
    check("stream_latency", first_pop_cyc - first_enq_cyc, 3);
    check("stream_no_bubble", last_pop_cyc - first_pop_cyc, 15);

    // Backpressure for 5 cycles mid-stream: buffer caps at 2, reads stop.
    do_reset();
    stream_k = 0;
    req_valid[0]    = 1'b1;
    req_data[0+:DW] = DW'(32'h100);
    for (int k = 0; k < 40; k++) begin
      out_ready = !(k >= 6 && k < 11);
      step();
      if (k == 9) begin
        check("bp_buf_full", dut.buf_count_q, 2'd2);
        check("bp_no_dequeue", fifo_dequeue, 1'b0);
      end
      if (acc_mask[0]) begin
        acc_mask[0] = 1'b0;
        stream_k++;
        req_valid[0] = (stream_k < 20);
        req_data[0+:DW] = DW'(32'h100 + stream_k);
      end
    end
    check("bp_beats", n_pops, 20);
    check("bp_drained", sb.size(), 0);

    // Mid-operation reset with a full output buffer and a backed-up FIFO.
    do_reset();
    out_ready = 1'b0;
    drive('1, 100);
    for (int k = 0; k < 8; k++) begin
      step();
      drive('1, 100);
    end
    check("pre_rst_buf_full", dut.buf_count_q, 2'd2);
    do_reset();
    out_ready = 1'b1;
    drive('1, 100);
    step();
    check("post_rst_ptr", last_winner, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      drive('0, 0);
    end
    check("post_rst_no_stale", sb.size(), 0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      out_ready = (int'($urandom_range(99)) < 70);
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        step();
        drive('1, 50);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step();
      drive('0, 0);
    end
    check("final_drained", sb.size(), 0);
    check("final_all_accepted", req_valid, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
